// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace unit: record kinds, serialiser states, queue slot layout.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package commit_trace_pkg;

    localparam logic [1:0] REC_REG   = 2'd0;
    localparam logic [1:0] REC_LOAD  = 2'd1;
    localparam logic [1:0] REC_STORE = 2'd2;
    localparam logic [1:0] REC_HALT  = 2'd3;

    // S_IDLE doubles as "presenting the first record of the head slot", and S_POP
    // is only ever a next-state answer meaning "slot finished": both keep the
    // stream at one record per cycle across slot boundaries.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_REG  = 3'd2,
        S_HALT = 3'd3,
        S_POP  = 3'd4
    } ser_state_e;

    // One captured commit. mem_data holds store data for stores, load data for loads.
    typedef struct packed {
        logic        halt;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [2:0]  write_reg;
        logic [15:0] write_data;
        logic [15:0] mem_addr;
        logic [15:0] mem_data;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    // First record a slot produces: memory, then register, then halt.
    function automatic ser_state_e first_state(input slot_t s);
        if (s.mem_read || s.mem_write) return S_MEM;
        else if (s.reg_write)          return S_REG;
        else                           return S_HALT;
    endfunction

    // Record following 'cur' within the same slot; S_POP when the slot is exhausted.
    function automatic ser_state_e next_after(input ser_state_e cur, input slot_t s);
        case (cur)
            S_MEM:   return s.reg_write ? S_REG : (s.halt ? S_HALT : S_POP);
            S_REG:   return s.halt ? S_HALT : S_POP;
            default: return S_POP;
        endcase
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Commit queue: DEPTH x W storage, ports push/push_data/pop/pop_data/full/empty.
// Latency: pushed entry visible on pop_data the cycle after push (show-ahead head).
// Backpressure: push ignored when full unless pop frees a slot in the same cycle.
module commit_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/commit_trace_unit.sv
// Commit trace producer: queues WB-stage commits and serialises them into REG/LOAD/STORE/HALT
//   records on a valid/ready stream; also keeps cycle, instruction and cache counters.
// Latency: first record of a commit is valid the cycle after capture; one record per cycle.
// Backpressure: rec_* held while rec_valid & ~rec_ready; trace_full asks proc to stall, and a
//   commit offered while full (with no same-cycle pop) is dropped and flags overflow.
module commit_trace_unit
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cm_valid,
    input  logic             cm_reg_write,
    input  logic [2:0]       cm_write_reg,
    input  logic [15:0]      cm_write_data,
    input  logic             cm_mem_read,
    input  logic             cm_mem_write,
    input  logic [15:0]      cm_mem_addr,
    input  logic [15:0]      cm_mem_din,
    input  logic [15:0]      cm_mem_dout,
    input  logic             cm_halt,
    input  logic             ic_req,
    input  logic             ic_hit,
    input  logic             dc_req,
    input  logic             dc_hit,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [1:0]       rec_kind,
    output logic [15:0]      rec_a,
    output logic [15:0]      rec_b,
    output logic             trace_full,
    output logic             overflow,
    output logic             halted,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] ic_req_cnt,
    output logic [CNT_W-1:0] ic_hit_cnt,
    output logic [CNT_W-1:0] dc_req_cnt,
    output logic [CNT_W-1:0] dc_hit_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + ONE : v;
    endfunction

    // ---------------- capture ----------------
    slot_t      in_slot;
    slot_t      head;
    logic       live;
    logic       any_flag;
    logic       push;
    logic       pop;
    logic       empty;
    ser_state_e state_q;
    ser_state_e state_d;
    ser_state_e cur;

    assign live     = cm_valid && !halted;
    assign any_flag = cm_reg_write || cm_mem_read || cm_mem_write || cm_halt;
    // A pop in the same cycle makes room, so a full queue does not drop that commit.
    assign push     = live && any_flag && (!trace_full || pop);

    always_comb begin
        in_slot            = '0;
        in_slot.halt       = cm_halt;
        in_slot.mem_write  = cm_mem_write;
        in_slot.mem_read   = cm_mem_read;
        in_slot.reg_write  = cm_reg_write;
        in_slot.write_reg  = cm_write_reg;
        in_slot.write_data = cm_write_data;
        in_slot.mem_addr   = cm_mem_addr;
        in_slot.mem_data   = cm_mem_write ? cm_mem_din : cm_mem_dout;
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .W     (SLOT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_slot),
        .pop       (pop),
        .pop_data  (head),
        .full      (trace_full),
        .empty     (empty)
    );

    // ---------------- status and counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
            inst_count  <= '0;
            ic_req_cnt  <= '0;
            ic_hit_cnt  <= '0;
            dc_req_cnt  <= '0;
            dc_hit_cnt  <= '0;
        end else begin
            if (live && any_flag && trace_full && !pop) overflow <= 1'b1;
            if (push && cm_halt)                         halted   <= 1'b1;
            // Counters freeze once halted, so the HALT record can read them live.
            cycle_count <= sat_inc(cycle_count, !halted);
            inst_count  <= sat_inc(inst_count, live && (cm_halt || cm_reg_write || cm_mem_write));
            ic_req_cnt  <= sat_inc(ic_req_cnt, !halted && ic_req);
            ic_hit_cnt  <= sat_inc(ic_hit_cnt, !halted && ic_hit);
            dc_req_cnt  <= sat_inc(dc_req_cnt, !halted && dc_req);
            dc_hit_cnt  <= sat_inc(dc_hit_cnt, !halted && dc_hit);
        end
    end

    // ---------------- serialiser ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign rec_valid = !empty;
    assign cur       = (state_q == S_IDLE) ? first_state(head) : state_q;
    assign done      = halted && empty && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (rec_valid && rec_ready) begin
            if (next_after(cur, head) == S_POP) begin
                // Last record of the slot: dequeue on this handshake.
                pop     = 1'b1;
                state_d = S_IDLE;
            end else begin
                state_d = next_after(cur, head);
            end
        end
    end

    always_comb begin
        rec_kind = REC_REG;
        rec_a    = '0;
        rec_b    = '0;
        if (rec_valid) begin
            case (cur)
                S_MEM: begin
                    rec_kind = head.mem_write ? REC_STORE : REC_LOAD;
                    rec_a    = head.mem_addr;
                    rec_b    = head.mem_data;
                end
                S_REG: begin
                    rec_kind = REC_REG;
                    rec_a    = {13'b0, head.write_reg};
                    rec_b    = head.write_data;
                end
                default: begin
                    rec_kind = REC_HALT;
                    rec_a    = inst_count[15:0];
                    rec_b    = cycle_count[15:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_unit.sv
module tb_commit_trace_unit;
    import commit_trace_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cm_valid = 0, cm_reg_write = 0, cm_mem_read = 0, cm_mem_write = 0, cm_halt = 0;
    logic [2:0]  cm_write_reg = 0;
    logic [15:0] cm_write_data = 0, cm_mem_addr = 0, cm_mem_din = 0, cm_mem_dout = 0;
    logic        ic_req = 0, ic_hit = 0, dc_req = 0, dc_hit = 0;
    logic        rec_valid, rec_ready = 0;
    logic [1:0]  rec_kind;
    logic [15:0] rec_a, rec_b;
    logic        trace_full, overflow, halted, done;
    logic [31:0] cycle_count, inst_count, ic_req_cnt, ic_hit_cnt, dc_req_cnt, dc_hit_cnt;

    int errors = 0;
    int checks = 0;

    commit_trace_unit #(.DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cm_valid(cm_valid), .cm_reg_write(cm_reg_write), .cm_write_reg(cm_write_reg),
        .cm_write_data(cm_write_data), .cm_mem_read(cm_mem_read), .cm_mem_write(cm_mem_write),
        .cm_mem_addr(cm_mem_addr), .cm_mem_din(cm_mem_din), .cm_mem_dout(cm_mem_dout),
        .cm_halt(cm_halt), .ic_req(ic_req), .ic_hit(ic_hit), .dc_req(dc_req), .dc_hit(dc_hit),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_a(rec_a), .rec_b(rec_b), .trace_full(trace_full), .overflow(overflow),
        .halted(halted), .done(done), .cycle_count(cycle_count), .inst_count(inst_count),
        .ic_req_cnt(ic_req_cnt), .ic_hit_cnt(ic_hit_cnt),
        .dc_req_cnt(dc_req_cnt), .dc_hit_cnt(dc_hit_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cm_valid = 0; cm_reg_write = 0; cm_mem_read = 0; cm_mem_write = 0; cm_halt = 0;
        cm_write_reg = 0; cm_write_data = 0; cm_mem_addr = 0; cm_mem_din = 0; cm_mem_dout = 0;
        ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
    endtask

    task automatic drive_store(input logic [15:0] addr, input logic [15:0] din);
        drive_idle();
        cm_valid = 1; cm_mem_write = 1; cm_mem_addr = addr; cm_mem_din = din;
    endtask

    // One table row: inputs applied for one cycle, plus the outputs expected at the
    // start of that cycle (i.e. produced by all earlier rows).
    typedef struct {
        logic        vld, rw, mr, mw, hlt;
        logic [2:0]  wreg;
        logic [15:0] wdata, addr, din, dout;
        logic        rdy;
        logic        e_vld;
        logic [1:0]  e_kind;
        logic [15:0] e_a, e_b;
        logic        e_full, e_ovf;
        int          e_inst;
    } vec_t;

    function automatic vec_t row(input logic rdy, input logic e_vld, input logic [1:0] e_kind,
                                 input logic [15:0] e_a, input logic [15:0] e_b,
                                 input logic e_full, input logic e_ovf, input int e_inst);
        vec_t v;
        v = '{default: 0};
        v.rdy = rdy; v.e_vld = e_vld; v.e_kind = e_kind; v.e_a = e_a; v.e_b = e_b;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_inst = e_inst;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t        v;
        logic        prev_vld, prev_rdy;
        logic [1:0]  prev_kind;
        logic [15:0] prev_a, prev_b;
        logic [1:0]  got_kind [2];
        logic [15:0] got_a [2];
        logic [15:0] got_b [2];
        int          got;

        // ---- table: load, fill to full, push+pop on full, drop, drain ----
        v = row(1, 0, 0, 0, 0, 0, 0, 0);
        v.vld = 1; v.rw = 1; v.wreg = 3; v.wdata = 16'hBEEF; v.mr = 1;
        v.addr = 16'h0040; v.dout = 16'hBEEF;
        tbl.push_back(v);
        tbl.push_back(row(1, 1, REC_LOAD, 16'h0040, 16'hBEEF, 0, 0, 1));
        tbl.push_back(row(1, 1, REC_REG, 16'h0003, 16'hBEEF, 0, 0, 1));
        for (int i = 0; i < 8; i++) begin
            v = row(0, i != 0, REC_STORE, (i != 0) ? 16'h0100 : 16'h0, (i != 0) ? 16'hA000 : 16'h0,
                    0, 0, 1 + i);
            if (i == 0) v.e_kind = REC_REG;
            v.vld = 1; v.mw = 1; v.addr = 16'h0100 + 16'(i); v.din = 16'hA000 + 16'(i);
            tbl.push_back(v);
        end
        v = row(1, 1, REC_STORE, 16'h0100, 16'hA000, 1, 0, 9);
        v.vld = 1; v.mw = 1; v.addr = 16'h0108; v.din = 16'hA008;
        tbl.push_back(v);
        v = row(0, 1, REC_STORE, 16'h0101, 16'hA001, 1, 0, 10);
        v.vld = 1; v.mw = 1; v.addr = 16'h0109; v.din = 16'hA009;
        tbl.push_back(v);
        tbl.push_back(row(1, 1, REC_STORE, 16'h0101, 16'hA001, 1, 1, 11));
        for (int j = 0; j < 7; j++)
            tbl.push_back(row(1, 1, REC_STORE, 16'h0102 + 16'(j), 16'hA002 + 16'(j), 0, 1, 11));
        tbl.push_back(row(0, 0, REC_REG, 0, 0, 0, 1, 11));

        // ---- reset state ----
        drive_idle();
        repeat (2) @(negedge clk);
        chk("rst_rec_valid", rec_valid, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_full", trace_full, 0);
        chk("rst_done", done, 0);

        // ---- idle 10 cycles after release ----
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("idle_cycle", cycle_count, 10);
        chk("idle_rec_valid", rec_valid, 0);
        chk("idle_inst", inst_count, 0);
        chk("idle_caches", ic_req_cnt | ic_hit_cnt | dc_req_cnt | dc_hit_cnt, 0);
        chk("idle_overflow", overflow, 0);

        // ---- cache pulses: ic_req x4, ic_hit x2, dc_req x3, dc_hit x1 ----
        for (int i = 0; i < 5; i++) begin
            ic_req = (i < 4); ic_hit = (i < 2); dc_req = (i < 3); dc_hit = (i < 1);
            @(negedge clk);
        end
        drive_idle();
        chk("pulse_cycle", cycle_count, 15);
        chk("ic_req_cnt", ic_req_cnt, 4);
        chk("ic_hit_cnt", ic_hit_cnt, 2);
        chk("dc_req_cnt", dc_req_cnt, 3);
        chk("dc_hit_cnt", dc_hit_cnt, 1);

        // ---- apply table ----
        foreach (tbl[k]) begin
            @(negedge clk);
            chk($sformatf("t%0d_vld", k), rec_valid, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                chk($sformatf("t%0d_kind", k), rec_kind, tbl[k].e_kind);
                chk($sformatf("t%0d_a", k), rec_a, tbl[k].e_a);
                chk($sformatf("t%0d_b", k), rec_b, tbl[k].e_b);
            end
            chk($sformatf("t%0d_full", k), trace_full, tbl[k].e_full);
            chk($sformatf("t%0d_ovf", k), overflow, tbl[k].e_ovf);
            chk($sformatf("t%0d_inst", k), inst_count, tbl[k].e_inst);
            drive_idle();
            cm_valid = tbl[k].vld; cm_reg_write = tbl[k].rw; cm_write_reg = tbl[k].wreg;
            cm_write_data = tbl[k].wdata; cm_mem_read = tbl[k].mr; cm_mem_write = tbl[k].mw;
            cm_mem_addr = tbl[k].addr; cm_mem_din = tbl[k].din; cm_mem_dout = tbl[k].dout;
            cm_halt = tbl[k].hlt; rec_ready = tbl[k].rdy;
        end

        // ---- reset with 3 slots queued ----
        rec_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_store(16'h0300 + 16'(i), 16'hC000 + 16'(i));
        end
        @(negedge clk);
        drive_idle();
        chk("preq_rec_valid", rec_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_rec_valid", rec_valid, 0);
        chk("mid_rst_cycle", cycle_count, 0);
        chk("mid_rst_inst", inst_count, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_dc_hit", dc_hit_cnt, 0);
        chk("mid_rst_halted", halted, 0);

        // ---- store then HALT, ready toggling ----
        @(negedge clk);
        rst_n = 1;
        drive_store(16'h0200, 16'h1234);
        @(negedge clk);
        drive_idle();
        cm_valid = 1; cm_halt = 1;
        @(negedge clk);
        drive_idle();
        got = 0;
        prev_vld = 0; prev_rdy = 1; prev_kind = 0; prev_a = 0; prev_b = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            if (prev_vld && !prev_rdy) begin
                chk("stall_vld", rec_valid, 1);
                chk("stall_kind", rec_kind, prev_kind);
                chk("stall_a", rec_a, prev_a);
                chk("stall_b", rec_b, prev_b);
            end
            rec_ready = c[0];
            if (rec_valid && rec_ready) begin
                got_kind[got] = rec_kind; got_a[got] = rec_a; got_b[got] = rec_b;
                got++;
            end
            prev_vld = rec_valid; prev_rdy = rec_ready;
            prev_kind = rec_kind; prev_a = rec_a; prev_b = rec_b;
            @(negedge clk);
        end
        rec_ready = 0;
        chk("halt_rec_count", got, 2);
        if (got == 2) begin
            chk("rec0_kind", got_kind[0], REC_STORE);
            chk("rec0_a", got_a[0], 16'h0200);
            chk("rec0_b", got_b[0], 16'h1234);
            chk("rec1_kind", got_kind[1], REC_HALT);
            chk("rec1_a", got_a[1], 2);
            chk("rec1_b", got_b[1], 2);
        end
        chk("halt_done", done, 1);
        chk("halt_halted", halted, 1);
        chk("halt_rec_valid", rec_valid, 0);

        // ---- commits and cache pulses after halt are ignored ----
        rec_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            cm_valid = 1; cm_reg_write = 1; cm_write_reg = 3'(i); cm_write_data = 16'h5555;
            dc_req = 1; dc_hit = 1; ic_req = 1;
            @(negedge clk);
            chk($sformatf("post_halt%0d_vld", i), rec_valid, 0);
        end
        drive_idle();
        @(negedge clk);
        chk("post_halt_inst", inst_count, 2);
        chk("post_halt_cycle", cycle_count, 2);
        chk("post_halt_dc_hit", dc_hit_cnt, 0);
        chk("post_halt_dc_req", dc_req_cnt, 0);
        chk("post_halt_ic_req", ic_req_cnt, 0);
        chk("post_halt_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
